// File: rtl/sd_request_arbiter.sv
// sd_request_arbiter: shares one SD card controller between two sector
// requesters. Round-robin grant that is held for a whole sector transfer.
// Byte strobes and read data are routed to the owner. A stall watchdog and a
// sector byte-count check report failures.
module sd_request_arbiter #(
    parameter int unsigned BYTES_PER_SECTOR = 512,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        op0,
    input  logic        op1,
    input  logic [25:0] sector0,
    input  logic [25:0] sector1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        grant0,
    output logic        grant1,
    output logic        byte_stb0,
    output logic        byte_stb1,
    output logic [7:0]  rdata,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        sd_op_code,
    output logic        sd_execute,
    output logic [25:0] sd_sector_address,
    output logic [7:0]  sd_outgoing_byte,
    input  logic [7:0]  sd_incoming_byte,
    input  logic        sd_finished_byte,
    input  logic        sd_finished_sector,
    input  logic        sd_busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] BPS = CW'(BYTES_PER_SECTOR);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        XFER,
        COMPLETE,
        ABORT
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;   // also identifies the current owner
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          exec_q, exec_d;
    logic          stb0_q, stb0_d;
    logic          stb1_q, stb1_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          op_q, op_d;
    logic [25:0]   addr_q, addr_d;

    logic [TW-1:0] timer_inc;
    logic          pick;
    logic          granted;
    logic          sector_ok;

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            exec_q       <= 1'b0;
            stb0_q       <= 1'b0;
            stb1_q       <= 1'b0;
            rdata_q      <= '0;
            op_q         <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            exec_q       <= exec_d;
            stb0_q       <= stb0_d;
            stb1_q       <= stb1_d;
            rdata_q      <= rdata_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
        end
    end

    // Next-state logic: arbitration, controller handshake, byte counting and watchdog.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        exec_d       = 1'b0;
        stb0_d       = 1'b0;
        stb1_d       = 1'b0;
        rdata_d      = rdata_q;
        op_d         = op_q;
        addr_d       = addr_q;
        timer_inc    = timer_q + TW'(1);
        pick         = (req0 && req1) ? ~last_grant_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = pick;
                    op_d         = pick ? op1 : op0;
                    addr_d       = pick ? sector1 : sector0;
                    timer_d      = '0;
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                    state_d      = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (!sd_busy) begin
                    exec_d  = 1'b1;
                    timer_d = '0;
                    state_d = XFER;
                end else if (timer_inc == TMO) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_inc;
                end
            end
            XFER: begin
                if (sd_finished_byte) begin
                    stb0_d  = ~last_grant_q;
                    stb1_d  = last_grant_q;
                    rdata_d = sd_incoming_byte;
                    timer_d = '0;
                    // Extra bytes leave the count at a full sector and mark the mismatch.
                    if (cnt_q == BPS) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    timer_d = timer_inc;
                end
                if (sd_finished_sector) begin
                    state_d = COMPLETE;
                end else if (!sd_finished_byte && timer_inc == TMO) begin
                    state_d = ABORT;
                end
            end
            COMPLETE: state_d = IDLE;
            ABORT:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        granted           = (state_q != IDLE);
        sector_ok         = (cnt_q == BPS) && !ovf_q;
        grant0            = granted && !last_grant_q;
        grant1            = granted && last_grant_q;
        done0             = (state_q == COMPLETE) && sector_ok && !last_grant_q;
        done1             = (state_q == COMPLETE) && sector_ok && last_grant_q;
        err0              = (((state_q == COMPLETE) && !sector_ok) || (state_q == ABORT)) && !last_grant_q;
        err1              = (((state_q == COMPLETE) && !sector_ok) || (state_q == ABORT)) && last_grant_q;
        byte_stb0         = stb0_q;
        byte_stb1         = stb1_q;
        rdata             = rdata_q;
        sd_op_code        = op_q;
        sd_execute        = exec_q;
        sd_sector_address = addr_q;
        sd_outgoing_byte  = grant0 ? wdata0 : (grant1 ? wdata1 : '0);
    end

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Testbench for sd_request_arbiter: table of sector transactions plus
// hand-written timeout and mid-transfer reset sequences, with a small
// controller model driving the sd_* side.
module tb_sd_request_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, op0, op1;
    logic [25:0] sector0, sector1;
    logic [7:0]  wdata0, wdata1;
    logic        grant0, grant1, byte_stb0, byte_stb1;
    logic [7:0]  rdata;
    logic        done0, done1, err0, err1;
    logic        sd_op_code, sd_execute;
    logic [25:0] sd_sector_address;
    logic [7:0]  sd_outgoing_byte;
    logic [7:0]  sd_incoming_byte;
    logic        sd_finished_byte, sd_finished_sector, sd_busy;

    sd_request_arbiter #(
        .BYTES_PER_SECTOR(512),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0              (req0),
        .req1              (req1),
        .op0               (op0),
        .op1               (op1),
        .sector0           (sector0),
        .sector1           (sector1),
        .wdata0            (wdata0),
        .wdata1            (wdata1),
        .grant0            (grant0),
        .grant1            (grant1),
        .byte_stb0         (byte_stb0),
        .byte_stb1         (byte_stb1),
        .rdata             (rdata),
        .done0             (done0),
        .done1             (done1),
        .err0              (err0),
        .err1              (err1),
        .sd_op_code        (sd_op_code),
        .sd_execute        (sd_execute),
        .sd_sector_address (sd_sector_address),
        .sd_outgoing_byte  (sd_outgoing_byte),
        .sd_incoming_byte  (sd_incoming_byte),
        .sd_finished_byte  (sd_finished_byte),
        .sd_finished_sector(sd_finished_sector),
        .sd_busy           (sd_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r0;
        bit          r1;
        bit          op0;
        bit          op1;
        logic [25:0] s0;
        logic [25:0] s1;
        int          nbytes;
        bit          coinc;
        int          busy;
        bit          drop;
        bit          exp_owner;
        bit          exp_done;
        int          exp_stb;
    } txn_t;

    txn_t tbl [12];
    txn_t post_rst [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-transaction observations
    int          stb0_n, stb1_n, done0_n, done1_n, err0_n, err1_n, exec_n;
    int          both_n, rdata_bad, wcap_bad;
    int          first_owner, grant_cyc, err_cyc;
    logic [25:0] addr_g;
    logic        op_g;
    logic        prev_g0, prev_g1;

    // controller model state
    bit mdl_active, mdl_coinc, mdl_phase, mdl_drove, mdl_chk_wr, mdl_force_busy, mdl_spur;
    int mdl_sent, mdl_nbytes, mdl_idx, cfg_busy, busy_left;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        stb0_n = 0; stb1_n = 0; done0_n = 0; done1_n = 0; err0_n = 0; err1_n = 0;
        exec_n = 0; both_n = 0; rdata_bad = 0; wcap_bad = 0;
        first_owner = -1; grant_cyc = 0; err_cyc = 0;
        addr_g = '0; op_g = 1'b0;
        mdl_active = 0; mdl_phase = 0; mdl_sent = 0; mdl_drove = 0; busy_left = 0;
        wdata0 = 8'h00; wdata1 = 8'h00;
    endtask

    task automatic check_reset_outs(input string p);
        chk({p, "_grant0"}, grant0, 0);
        chk({p, "_grant1"}, grant1, 0);
        chk({p, "_stb0"}, byte_stb0, 0);
        chk({p, "_stb1"}, byte_stb1, 0);
        chk({p, "_done0"}, done0, 0);
        chk({p, "_done1"}, done1, 0);
        chk({p, "_err0"}, err0, 0);
        chk({p, "_err1"}, err1, 0);
        chk({p, "_execute"}, sd_execute, 0);
        chk({p, "_rdata"}, rdata, 0);
        chk({p, "_op_code"}, sd_op_code, 0);
        chk({p, "_sector_addr"}, sd_sector_address, 0);
        chk({p, "_outgoing"}, sd_outgoing_byte, 0);
    endtask

    // One clock: observe DUT after the edge, then drive the controller side.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        // the byte the DUT presented when the model finished it on this edge
        if (mdl_drove && mdl_chk_wr && sd_outgoing_byte != 8'(mdl_idx)) wcap_bad++;
        mdl_drove = 0;

        if (grant0 && grant1) both_n++;
        if (grant0 && !prev_g0 && first_owner < 0) begin
            first_owner = 0; addr_g = sd_sector_address; op_g = sd_op_code;
            grant_cyc = cyc; busy_left = cfg_busy; mdl_chk_wr = op0;
        end
        if (grant1 && !prev_g1 && first_owner < 0) begin
            first_owner = 1; addr_g = sd_sector_address; op_g = sd_op_code;
            grant_cyc = cyc; busy_left = cfg_busy; mdl_chk_wr = op1;
        end
        prev_g0 = grant0;
        prev_g1 = grant1;
        if (sd_execute) exec_n++;
        if (byte_stb0) begin
            if (rdata != 8'(stb0_n)) rdata_bad++;
            stb0_n++;
            wdata0 = 8'(stb0_n);
        end
        if (byte_stb1) begin
            if (rdata != 8'(stb1_n)) rdata_bad++;
            stb1_n++;
            wdata1 = 8'(stb1_n);
        end
        if (done0) done0_n++;
        if (done1) done1_n++;
        if ((err0 || err1) && err0_n == 0 && err1_n == 0) err_cyc = cyc;
        if (err0) err0_n++;
        if (err1) err1_n++;

        // controller model: one byte every other cycle after execute
        sd_finished_byte   = 1'b0;
        sd_finished_sector = 1'b0;
        sd_busy = mdl_force_busy || (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (sd_execute) begin
            mdl_active = 1; mdl_sent = 0; mdl_phase = 0;
        end
        if (mdl_active) begin
            if (!mdl_phase) begin
                if (mdl_sent < mdl_nbytes) begin
                    sd_finished_byte = 1'b1;
                    sd_incoming_byte = 8'(mdl_sent);
                    mdl_drove = 1;
                    mdl_idx = mdl_sent;
                    mdl_sent++;
                    if (mdl_sent == mdl_nbytes && mdl_coinc) begin
                        sd_finished_sector = 1'b1;
                        mdl_active = 0;
                    end
                end else begin
                    sd_finished_sector = 1'b1;
                    mdl_active = 0;
                end
            end
            mdl_phase = ~mdl_phase;
        end else if (mdl_spur) begin
            sd_finished_byte   = cyc[0];
            sd_finished_sector = cyc[0];
            sd_incoming_byte   = 8'hA5;
        end
    endtask

    task automatic run_txn(input txn_t t, input string nm);
        int n;
        logic [25:0] exp_addr;
        bit exp_op;
        clear_counts();
        req0 = t.r0; req1 = t.r1; op0 = t.op0; op1 = t.op1;
        sector0 = t.s0; sector1 = t.s1;
        mdl_nbytes = t.nbytes; mdl_coinc = t.coinc; cfg_busy = t.busy;
        n = 0;
        while (done0_n + done1_n + err0_n + err1_n == 0 && n < 5000) begin
            tick();
            n++;
            if (t.drop && first_owner >= 0) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk({nm, "_finished_in_bound"}, (n < 5000) ? 1 : 0, 1);
        exp_addr = t.exp_owner ? t.s1 : t.s0;
        exp_op   = t.exp_owner ? t.op1 : t.op0;
        chk({nm, "_owner"}, first_owner, t.exp_owner);
        chk({nm, "_sector_addr"}, addr_g, exp_addr);
        chk({nm, "_op_code"}, op_g, exp_op);
        chk({nm, "_execute_count"}, exec_n, 1);
        chk({nm, "_owner_stb"}, t.exp_owner ? stb1_n : stb0_n, t.exp_stb);
        chk({nm, "_other_stb"}, t.exp_owner ? stb0_n : stb1_n, 0);
        chk({nm, "_done"}, t.exp_owner ? done1_n : done0_n, t.exp_done ? 1 : 0);
        chk({nm, "_err"}, t.exp_owner ? err1_n : err0_n, t.exp_done ? 0 : 1);
        chk({nm, "_other_done_err"}, t.exp_owner ? (done0_n + err0_n) : (done1_n + err1_n), 0);
        chk({nm, "_rdata_seq_bad"}, rdata_bad, 0);
        chk({nm, "_wdata_capture_bad"}, wcap_bad, 0);
        chk({nm, "_grants_both_high"}, both_n, 0);
        tick();
        chk({nm, "_grant_dropped"}, grant0 | grant1, 0);
    endtask

    initial begin
        int n;
        //          r0 r1 op0 op1 s0            s1            nb   co busy dr own done stb
        tbl[0]  = '{1, 1, 0, 1, 26'h0000010, 26'h0000020, 512, 0, 0, 0, 0, 1, 512};
        tbl[1]  = '{1, 1, 0, 1, 26'h0000011, 26'h0000021, 512, 0, 0, 0, 1, 1, 512};
        tbl[2]  = '{1, 1, 0, 1, 26'h0000012, 26'h0000022, 512, 0, 0, 0, 0, 1, 512};
        tbl[3]  = '{1, 1, 0, 1, 26'h0000013, 26'h0000023, 512, 0, 0, 0, 1, 1, 512};
        tbl[4]  = '{1, 1, 0, 1, 26'h0000014, 26'h0000024, 512, 0, 0, 0, 0, 1, 512};
        tbl[5]  = '{1, 1, 0, 1, 26'h0000015, 26'h0000025, 512, 0, 0, 0, 1, 1, 512};
        tbl[6]  = '{1, 0, 0, 0, 26'h0001234, 26'h0000000, 512, 0, 0, 0, 0, 1, 512};
        tbl[7]  = '{0, 1, 0, 1, 26'h0000000, 26'h3ABCDEF, 512, 0, 5, 1, 1, 1, 512};
        tbl[8]  = '{1, 0, 0, 0, 26'h0000777, 26'h0000000, 511, 0, 0, 0, 0, 0, 511};
        tbl[9]  = '{0, 1, 0, 0, 26'h0000000, 26'h2000001, 512, 1, 0, 0, 1, 1, 512};
        tbl[10] = '{1, 0, 0, 0, 26'h0000099, 26'h0000000, 513, 0, 0, 0, 0, 0, 513};
        tbl[11] = '{0, 1, 0, 0, 26'h0000000, 26'h0000456, 511, 1, 0, 0, 1, 0, 511};
        post_rst[0] = '{1, 1, 0, 0, 26'h0000A00, 26'h0000B00, 512, 0, 0, 0, 0, 1, 512};
        post_rst[1] = '{1, 1, 0, 0, 26'h0000A01, 26'h0000B01, 512, 0, 0, 0, 1, 1, 512};

        rst_n = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; sector0 = '0; sector1 = '0;
        sd_incoming_byte = '0; sd_finished_byte = 0; sd_finished_sector = 0; sd_busy = 0;
        mdl_force_busy = 0; mdl_spur = 0; mdl_chk_wr = 0; mdl_coinc = 0; mdl_nbytes = 0;
        mdl_idx = 0; cfg_busy = 0;
        prev_g0 = 0; prev_g1 = 0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(tbl[i], $sformatf("txn%0d", i));

        // Controller stays busy: watchdog aborts, stray finish strobes ignored.
        clear_counts();
        req0 = 1'b1; op0 = 1'b0; sector0 = 26'h00ABCDE; cfg_busy = 0;
        mdl_force_busy = 1; mdl_spur = 1;
        n = 0;
        while (err0_n + err1_n + done0_n + done1_n == 0 && n < 100) begin
            tick();
            n++;
        end
        req0 = 1'b0;
        chk("timeout_finished_in_bound", (n < 100) ? 1 : 0, 1);
        chk("timeout_owner", first_owner, 0);
        chk("timeout_err_latency", err_cyc - grant_cyc, 16);
        chk("timeout_err0", err0_n, 1);
        chk("timeout_done0", done0_n, 0);
        chk("timeout_execute", exec_n, 0);
        chk("timeout_stray_stb", stb0_n + stb1_n, 0);
        tick();
        chk("timeout_grant_dropped", grant0 | grant1, 0);
        mdl_force_busy = 0; mdl_spur = 0;
        repeat (3) tick();
        chk("timeout_no_late_execute", exec_n, 0);

        // Asynchronous reset in the middle of a write transfer.
        clear_counts();
        req0 = 1'b1; op0 = 1'b1; sector0 = 26'h1555555; mdl_nbytes = 512; mdl_coinc = 0;
        n = 0;
        while (stb0_n < 100 && n < 2000) begin
            tick();
            n++;
        end
        chk("midrst_reached_byte100", stb0_n, 100);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        req0 = 1'b0;
        mdl_active = 0; mdl_drove = 0;
        sd_finished_byte = 0; sd_finished_sector = 0; sd_busy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_held_execute", sd_execute, 0);
        chk("midrst_held_err0", err0, 0);
        chk("midrst_held_done0", done0, 0);
        rst_n = 1'b1;
        prev_g0 = 0; prev_g1 = 0;
        run_txn(post_rst[0], "postrst0");
        run_txn(post_rst[1], "postrst1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

endmodule
